// File: rtl/camellia_pkg.sv
// camellia_pkg: shared types and constants for the two-channel camellia core scheduler.
package camellia_pkg;
   localparam int BLK_W = 128;
   localparam int KEY_W = 256;
   localparam logic [1:0] KS_128 = 2'b00;
   localparam logic [1:0] KS_192 = 2'b01;
   localparam logic [1:0] KS_256 = 2'b10;
   typedef enum logic [2:0] {IDLE, KEY, BLK, RUN, RSP} state_t;
endpackage

// File: rtl/camellia_arbiter_if.sv
// camellia_arbiter_if: requester-side and core-side handshakes of the arbiter.
interface camellia_arbiter_if;
   import camellia_pkg::*;
   logic [1:0]         i_kwrite;
   logic [KEY_W-1:0]   i_key;
   logic [1:0]         i_key_size;
   logic               i_encrypt;
   logic [1:0]         i_req_valid;
   logic [2*BLK_W-1:0] i_req_block;
   logic [1:0]         o_req_ready;
   logic [1:0]         o_rsp_valid;
   logic [BLK_W-1:0]   o_rsp_data;
   logic [1:0]         i_rsp_ready;
   logic               o_core_reset_n;
   logic               o_core_kvalid;
   logic [KEY_W-1:0]   o_core_key;
   logic [1:0]         o_core_key_size;
   logic               o_core_encrypt;
   logic               i_core_kready;
   logic               o_core_pvalid;
   logic [BLK_W-1:0]   o_core_block;
   logic               i_core_pready;
   logic               i_core_valid;
   logic [BLK_W-1:0]   i_core_data;
   logic               o_core_ready;

   modport slave (
      input  i_kwrite, i_key, i_key_size, i_encrypt, i_req_valid, i_req_block, i_rsp_ready,
             i_core_kready, i_core_pready, i_core_valid, i_core_data,
      output o_req_ready, o_rsp_valid, o_rsp_data, o_core_reset_n, o_core_kvalid, o_core_key,
             o_core_key_size, o_core_encrypt, o_core_pvalid, o_core_block, o_core_ready
   );
   modport master (
      output i_kwrite, i_key, i_key_size, i_encrypt, i_req_valid, i_req_block, i_rsp_ready,
             i_core_kready, i_core_pready, i_core_valid, i_core_data,
      input  o_req_ready, o_rsp_valid, o_rsp_data, o_core_reset_n, o_core_kvalid, o_core_key,
             o_core_key_size, o_core_encrypt, o_core_pvalid, o_core_block, o_core_ready
   );
endinterface

// File: rtl/camellia_rr_arb2.sv
// camellia_rr_arb2: two-way round-robin grant; ptr wins when it requests.
module camellia_rr_arb2 (
   input  logic [1:0] i_req,
   input  logic       i_ptr,
   output logic       o_any,
   output logic       o_gnt
);
   assign o_any = |i_req;
   assign o_gnt = i_req[i_ptr] ? i_ptr : ~i_ptr;
endmodule

// File: rtl/camellia_arbiter.sv
// camellia_arbiter: shares one camellia core between two requesters, reloading the
// core key only when the granted channel's context is not already resident.
module camellia_arbiter
   import camellia_pkg::*;
(
   input logic i_clk,
   input logic i_reset,
   camellia_arbiter_if.slave bus
);
   state_t           r_state;
   logic             r_gnt, r_ptr, r_loaded_vld, r_loaded_ch;
   logic [KEY_W-1:0] r_key [2];
   logic [1:0]       r_size [2];
   logic [1:0]       r_enc, r_dirty;
   logic             w_any, w_gnt, w_reload;
   logic [1:0]       w_gnt_oh;

   camellia_rr_arb2 u_arb (.i_req(bus.i_req_valid), .i_ptr(r_ptr), .o_any(w_any), .o_gnt(w_gnt));

   // A write landing in the grant cycle also forces a reload.
   assign w_reload = !r_loaded_vld || r_loaded_ch != w_gnt || r_dirty[w_gnt] || bus.i_kwrite[w_gnt];
   assign w_gnt_oh = r_gnt ? 2'b10 : 2'b01;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= IDLE;
         r_gnt        <= 1'b0;
         r_ptr        <= 1'b0;
         r_loaded_vld <= 1'b0;
         r_loaded_ch  <= 1'b0;
         r_key        <= '{default: '0};
         r_size       <= '{default: '0};
         r_enc        <= 2'b00;
         r_dirty      <= 2'b00;
      end else begin
         case (r_state)
            IDLE: if (w_any) begin
               r_gnt   <= w_gnt;
               r_ptr   <= ~w_gnt;
               r_state <= w_reload ? KEY : BLK;
            end
            KEY: if (bus.i_core_kready) begin
               r_loaded_vld   <= 1'b1;
               r_loaded_ch    <= r_gnt;
               r_dirty[r_gnt] <= 1'b0;
               r_state        <= BLK;
            end
            BLK: if (bus.i_core_pready) r_state <= RUN;
            RUN: if (bus.i_core_valid) r_state <= RSP;
            RSP: if (bus.i_core_valid && bus.i_rsp_ready[r_gnt]) r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
         // Later assignment wins, so a write during the key handshake keeps dirty set.
         for (int c = 0; c < 2; c++) begin
            if (bus.i_kwrite[c]) begin
               r_key[c]   <= bus.i_key;
               r_size[c]  <= bus.i_key_size;
               r_enc[c]   <= bus.i_encrypt;
               r_dirty[c] <= 1'b1;
            end
         end
      end
   end

   assign bus.o_core_reset_n  = ~i_reset;
   assign bus.o_core_kvalid   = r_state == KEY;
   assign bus.o_core_pvalid   = r_state == BLK;
   assign bus.o_core_key      = (r_state == KEY) ? r_key[r_gnt] : '0;
   assign bus.o_core_key_size = (r_state == KEY) ? r_size[r_gnt] : KS_128;
   assign bus.o_core_encrypt  = (r_state == KEY || r_state == BLK) && r_enc[r_gnt];
   assign bus.o_core_block    = (r_state != BLK) ? '0 :
                                r_gnt ? bus.i_req_block[2*BLK_W-1:BLK_W] : bus.i_req_block[BLK_W-1:0];
   assign bus.o_req_ready     = (r_state == BLK && bus.i_core_pready) ? w_gnt_oh : 2'b00;
   assign bus.o_rsp_valid     = (r_state == RSP) ? w_gnt_oh : 2'b00;
   assign bus.o_rsp_data      = bus.i_core_data;
   assign bus.o_core_ready    = r_state == RSP && bus.i_rsp_ready[r_gnt];
endmodule

// File: tb/tb_camellia_arbiter.sv
// tb_camellia_arbiter: directed scenarios against a behavioural core model, with a
// response scoreboard checked by an independent monitor.
module tb_camellia_arbiter;
   import camellia_pkg::*;
   localparam logic [127:0] PT = 128'h0123456789abcdeffedcba9876543210;
   localparam logic [127:0] CT = 128'h67673138549669730857065648eabe43;
   localparam logic [255:0] K  = {128'h0, PT};

   typedef struct packed {logic [1:0] oh; logic [127:0] data;} exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   camellia_arbiter_if dif();
   camellia_arbiter dut (.i_clk(clk), .i_reset(rst), .bus(dif));

   exp_t q[$];
   int checks = 0;
   int errors = 0;
   int nkey = 0;
   int n0;

   // Core model: known camellia vector, anything else yields a distinguishable pattern.
   logic [255:0] c_key = '0;
   logic         c_enc = 1'b0;
   logic [127:0] c_blk = '0;
   logic [127:0] c_data = '0;
   logic         c_valid = 1'b0;
   int           c_cnt = 0;

   function automatic logic [127:0] core_f(logic [255:0] k, logic e, logic [127:0] b);
      if (k == K && e && b == PT) return CT;
      if (k == K && !e && b == CT) return PT;
      return b ^ k[127:0] ^ {128{e}};
   endfunction

   assign dif.i_core_kready = c_cnt == 0 && !c_valid;
   assign dif.i_core_pready = c_cnt == 0 && !c_valid;
   assign dif.i_core_valid  = c_valid;
   assign dif.i_core_data   = c_data;

   always @(posedge clk) begin
      if (!dif.o_core_reset_n) begin
         c_valid <= 1'b0;
         c_cnt   <= 0;
         c_data  <= '0;
      end else begin
         if (dif.o_core_kvalid && dif.i_core_kready) begin
            c_key <= dif.o_core_key;
            nkey  <= nkey + 1;
         end
         if (dif.o_core_pvalid && dif.i_core_pready) begin
            c_blk <= dif.o_core_block;
            c_enc <= dif.o_core_encrypt;
            c_cnt <= 3;
         end else if (c_cnt == 1) begin
            c_cnt   <= 0;
            c_valid <= 1'b1;
            c_data  <= core_f(c_key, c_enc, c_blk);
         end else if (c_cnt > 1) begin
            c_cnt <= c_cnt - 1;
         end
         if (c_valid && dif.o_core_ready) c_valid <= 1'b0;
      end
   end

   task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   initial forever begin
      @(negedge clk);
      if (!rst && dif.o_rsp_valid != 2'b00) begin
         if (q.size() == 0) chk("rsp_unexpected", {dif.o_rsp_valid, dif.o_rsp_data}, '0);
         else begin
            chk("rsp", {dif.o_rsp_valid, dif.o_rsp_data}, {q[0].oh, q[0].data});
            void'(q.pop_front());
         end
      end
   end

   task automatic kwrite(input logic [1:0] ch, input logic enc);
      dif.i_kwrite   = ch;
      dif.i_key      = K;
      dif.i_key_size = KS_128;
      dif.i_encrypt  = enc;
      @(posedge clk);
      #1 dif.i_kwrite = 2'b00;
   endtask

   // phase: 1 = expect kvalid after grant, 0 = expect pvalid, 2 = no grant-latency check
   task automatic serve(input int ch, input logic [127:0] blk, input int phase);
      dif.i_req_valid[ch] = 1'b1;
      dif.i_req_block[ch*128 +: 128] = blk;
      if (phase != 2) begin
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("grant_phase_ch%0d", ch), {dif.o_core_kvalid, dif.o_core_pvalid},
             phase == 1 ? 2'b10 : 2'b01);
      end
      for (int i = 0; i < 100 && !dif.o_req_ready[ch]; i++) @(negedge clk);
      chk($sformatf("req_ready_ch%0d", ch), dif.o_req_ready[ch], 1'b1);
      @(posedge clk);
      #1 dif.i_req_valid[ch] = 1'b0;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 300 && q.size() != 0; i++) @(posedge clk);
      chk(name, q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic reset_chk(input string tag);
      chk({tag, "_core_reset_n"}, dif.o_core_reset_n, 1'b0);
      chk({tag, "_handshakes"}, {dif.o_core_kvalid, dif.o_core_pvalid, dif.o_req_ready, dif.o_rsp_valid,
                                 dif.o_core_ready, dif.o_core_encrypt, dif.o_core_key_size}, '0);
      chk({tag, "_key"}, dif.o_core_key, '0);
      chk({tag, "_block"}, dif.o_core_block, '0);
   endtask

   initial begin
      dif.i_kwrite    = 2'b00;
      dif.i_key       = '0;
      dif.i_key_size  = 2'b00;
      dif.i_encrypt   = 1'b0;
      dif.i_req_valid = 2'b00;
      dif.i_req_block = '0;
      dif.i_rsp_ready = 2'b11;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_chk("reset");
      @(posedge clk);
      #1 rst = 1'b0;
      kwrite(2'b01, 1'b1);
      kwrite(2'b10, 1'b0);

      n0 = nkey;
      q.push_back({2'b01, CT});
      serve(0, PT, 1);
      drain("drain_single");
      chk("keyloads_single", nkey - n0, 1);

      n0 = nkey;
      q.push_back({2'b01, CT});
      serve(0, PT, 0);
      drain("drain_reuse");
      chk("keyloads_reuse", nkey - n0, 0);

      n0 = nkey;
      q.push_back({2'b10, PT});
      serve(1, CT, 1);
      drain("drain_switch");
      chk("keyloads_switch", nkey - n0, 1);

      n0 = nkey;
      q.push_back({2'b01, CT});
      fork
         serve(0, PT, 1);
         begin
            for (int i = 0; i < 100 && !dif.o_req_ready[0]; i++) @(negedge clk);
            @(posedge clk);
            #1 kwrite(2'b01, 1'b1);
         end
      join
      drain("drain_midrun");
      chk("keyloads_midrun", nkey - n0, 1);
      n0 = nkey;
      q.push_back({2'b01, CT});
      serve(0, PT, 1);
      drain("drain_after_midrun");
      chk("keyloads_after_midrun", nkey - n0, 1);

      dif.i_req_valid[0] = 1'b1;
      dif.i_req_block[127:0] = PT;
      for (int i = 0; i < 100 && !dif.o_req_ready[0]; i++) @(negedge clk);
      chk("req_ready_before_abort", dif.o_req_ready[0], 1'b1);
      @(posedge clk);
      #1 dif.i_req_valid[0] = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 reset_chk("abort");
      @(posedge clk);
      #1 rst = 1'b0;
      kwrite(2'b01, 1'b1);
      kwrite(2'b10, 1'b0);

      n0 = nkey;
      q.push_back({2'b01, CT});
      q.push_back({2'b10, PT});
      fork
         serve(0, PT, 1);
         serve(1, CT, 2);
      join
      drain("drain_contention");
      chk("keyloads_contention", nkey - n0, 2);

      n0 = nkey;
      q.push_back({2'b01, CT});
      serve(0, PT, 1);
      drain("drain_ptr_single");
      q.push_back({2'b10, PT});
      q.push_back({2'b01, CT});
      fork
         serve(0, PT, 2);
         serve(1, CT, 1);
      join
      drain("drain_ptr_contention");
      chk("keyloads_ptr", nkey - n0, 3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1);
   end
endmodule
